ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit and IF/ID pipeline register for the five-stage MIPS pipeline.
- Initiator side of the instruction-memory read interface: owns the PC, drives the fetch address to the instruction memory, takes the returned word, and registers it into the IF/ID latch.
- Computes the next PC from ID-stage control: sequential, branch, jump or register jump, with a delay slot.
- Handles stall, exception flush and fetch address faults.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_DEPTH, 4096, number of valid instruction words; word index must be < IM_DEPTH.
- EXC_ADEL, 5'd4, exception code for an instruction-fetch address error.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- im_pc  output  32  fetch byte address to the instruction memory; equals the PC register.
- im_instr  input  32  instruction word returned combinationally for im_pc.
- stall  input  1  hazard stall from the ID stage.
- flush  input  1  exception or eret flush.
- flush_target  input  32  PC to load on flush.
- npc_sel  input  2  ID-stage next-PC select: 0 = seq, 1 = branch, 2 = jump, 3 = jr.
- branch_taken  input  1  branch compare result from ID.
- jr_target  input  32  forwarded rs value for jr/jalr.
- if_id_instr  output  32  registered instruction.
- if_id_pc  output  32  registered PC of that instruction.
- if_id_pc8  output  32  if_id_pc + 8, the link address.
- if_id_exc  output  5  registered exception code; 0 = none.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (reset low, asynchronous): PC = RESET_PC; if_id_instr = 0, if_id_pc = 0, if_id_exc = 0, if_id_valid = 0. if_id_pc8 reads 8 because it is a combinational function of if_id_pc. Release is synchronous to the next rising edge.
- im_pc is combinational from the PC register. Memory latency is zero: im_instr is valid in the same cycle.
- Fetch fault: PC[1:0] != 0, or PC < IM_BASE, or (PC - IM_BASE) >> 2 >= IM_DEPTH.
  - On a fault, the word captured into IF/ID is 32'h0 (nop) and if_id_exc = EXC_ADEL.
  - Otherwise the captured word is im_instr and if_id_exc = 0.
- Next PC, all arithmetic modulo 2^32, with seq = PC + 4:
  - npc_sel 0: seq.
  - npc_sel 1: if branch_taken, if_id_pc + 4 + (sign-extended if_id_instr[15:0] << 2); else seq.
  - npc_sel 2: {if_id_pc+4 [31:28], if_id_instr[25:0], 2'b00}.
  - npc_sel 3: jr_target, used unmodified; misalignment is caught by the fault check on the next fetch.
- Delay slot: a redirect does not squash the instruction being fetched in the same cycle. That instruction enters IF/ID normally.
- Redirects are honoured only when if_id_valid = 1. When if_id_valid = 0, npc_sel is treated as 0.
- Priority per cycle, highest first:
  1. flush: PC <= flush_target; IF/ID <= {instr 0, pc 0, exc 0, valid 0}. Overrides stall and npc_sel.
  2. stall: PC and all IF/ID registers hold. npc_sel is ignored.
  3. normal: PC <= next PC; IF/ID <= {fetched word, PC, fault code, valid 1}.
- A faulting fetch still advances the PC normally. The exception is taken downstream, which asserts flush.
- Simultaneous flush and stall: flush wins.
- Reset during stall or flush: reset wins immediately (asynchronous).
- PC wrap from 32'hFFFF_FFFC + 4 gives 0. This is a fault unless IM_BASE = 0.
- No combinational path from stall, flush or npc_sel to im_pc.

Test Plan:
- Reset release, with im_instr = word(PC), no stall:
  - im_pc sequence is 3000, 3004, 3008.
  - if_id_pc lags by one cycle.
  - if_id_valid rises on the first edge.
  - if_id_pc8 = if_id_pc + 8.
- Branch with if_id_pc = 3004, imm = 16'hFFFE, branch_taken = 1, npc_sel = 1:
  - Delay slot 3008 is fetched.
  - Next im_pc = 3004 + 4 - 8 = 3000.
  - With branch_taken = 0, next im_pc = 300C.
- Jump with if_id_instr[25:0] = 26'h0000C10 at if_id_pc 3000, npc_sel = 2: next im_pc after the delay slot is 3040. jr with jr_target = 3100: next im_pc = 3100.
- stall held for 3 cycles: im_pc and all IF/ID outputs remain constant. Fetch resumes from the held PC.
- flush and stall together, flush_target = 4180: next im_pc = 4180, if_id_valid = 0, if_id_instr = 0.
- Fetch faults, each giving if_id_exc = 4, if_id_instr = 0, if_id_valid = 1, and PC still advancing:
  - jr_target = 3002.
  - PC = 3000 + 4*IM_DEPTH.
  - PC = 2FFC.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage and IF/ID latch for the five-stage MIPS pipeline.
// Instruction memory answers combinationally: im_instr is valid for im_pc in the same cycle.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 4096,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic [1:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc8,
    output logic [4:0]  if_id_exc,
    output logic        if_id_valid
);

    localparam logic [1:0] SEL_SEQ    = 2'd0;
    localparam logic [1:0] SEL_BRANCH = 2'd1;
    localparam logic [1:0] SEL_JUMP   = 2'd2;
    localparam logic [1:0] SEL_JR     = 2'd3;

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [4:0]  if_id_exc_q, if_id_exc_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic [31:0] im_offset;
    logic        fetch_fault;
    logic [31:0] seq_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] br_offset;
    logic [1:0]  eff_sel;
    logic [31:0] next_pc;

    // Out-of-window fetches capture a nop and carry the address-error code downstream.
    assign im_offset   = pc_q - IM_BASE;
    assign fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) ||
                         ({2'b00, im_offset[31:2]} >= IM_DEPTH);

    assign seq_pc    = pc_q + 32'd4;
    assign ifid_pc4  = if_id_pc_q + 32'd4;
    assign br_offset = {{14{if_id_instr_q[15]}}, if_id_instr_q[15:0], 2'b00};
    // A bubble in IF/ID carries no control, so only sequential fetch is meaningful then.
    assign eff_sel   = if_id_valid_q ? npc_sel : SEL_SEQ;

    always_comb begin
        next_pc = seq_pc;
        case (eff_sel)
            SEL_SEQ:    next_pc = seq_pc;
            SEL_BRANCH: next_pc = branch_taken ? (ifid_pc4 + br_offset) : seq_pc;
            SEL_JUMP:   next_pc = {ifid_pc4[31:28], if_id_instr_q[25:0], 2'b00};
            SEL_JR:     next_pc = jr_target;
            default:    next_pc = seq_pc;
        endcase
    end

    // flush beats stall beats normal advance; the delay-slot fetch is never squashed.
    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_exc_d   = if_id_exc_q;
        if_id_valid_d = if_id_valid_q;
        if (flush) begin
            pc_d          = flush_target;
            if_id_instr_d = 32'h0;
            if_id_pc_d    = 32'h0;
            if_id_exc_d   = 5'd0;
            if_id_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d          = next_pc;
            if_id_instr_d = fetch_fault ? 32'h0 : im_instr;
            if_id_pc_d    = pc_q;
            if_id_exc_d   = fetch_fault ? EXC_ADEL : 5'd0;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            if_id_instr_q <= 32'h0;
            if_id_pc_q    <= 32'h0;
            if_id_exc_q   <= 5'd0;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_exc_q   <= if_id_exc_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign im_pc       = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc8   = if_id_pc_q + 32'd8;
    assign if_id_exc   = if_id_exc_q;
    assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed pipeline scenarios followed by random control traffic,
// all checked against an arithmetic model of the fetch stage kept in the bench.
module tb_ifu_fetch;

    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int          IM_DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] im_pc;
    logic [31:0] im_instr;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_target = 32'h0;
    logic [1:0]  npc_sel = 2'd0;
    logic        branch_taken = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc8;
    logic [4:0]  if_id_exc;
    logic        if_id_valid;

    logic [31:0] mem [IM_DEPTH];
    logic [31:0] im_off;

    int n_checks = 0;
    int n_fail   = 0;

    // expected architectural state
    logic [31:0] e_pc    = 32'h0000_3000;
    logic [31:0] e_instr = 32'h0;
    logic [31:0] e_ifpc  = 32'h0;
    logic [4:0]  e_exc   = 5'd0;
    logic        e_valid = 1'b0;

    ifu_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .im_pc        (im_pc),
        .im_instr     (im_instr),
        .stall        (stall),
        .flush        (flush),
        .flush_target (flush_target),
        .npc_sel      (npc_sel),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_pc8    (if_id_pc8),
        .if_id_exc    (if_id_exc),
        .if_id_valid  (if_id_valid)
    );

    always #5 clk = ~clk;

    // zero-latency instruction memory; outside the window it returns junk
    assign im_off   = im_pc - IM_BASE;
    assign im_instr = (im_off < 32'(4 * IM_DEPTH)) ? mem[im_off[13:2]] : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".im_pc"}, im_pc, e_pc);
        check({tag, ".instr"}, if_id_instr, e_instr);
        check({tag, ".pc"}, if_id_pc, e_ifpc);
        check({tag, ".pc8"}, if_id_pc8, e_ifpc + 32'd8);
        check({tag, ".exc"}, {27'd0, if_id_exc}, {27'd0, e_exc});
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    endtask

    function automatic bit is_fault(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(IM_BASE);
        return (a % 4 != 0) || (off < 0) || (off / 4 >= IM_DEPTH);
    endfunction

    // one clock with the given ID-side controls; the model advances alongside
    task automatic step(input string tag, input logic st, input logic fl, input logic [31:0] ft,
                        input logic [1:0] sel, input logic tk, input logic [31:0] jt);
        logic [31:0] n_pc, n_instr, n_ifpc;
        logic [4:0]  n_exc;
        logic        n_valid;
        int          disp;
        stall = st; flush = fl; flush_target = ft;
        npc_sel = sel; branch_taken = tk; jr_target = jt;
        n_pc = e_pc; n_instr = e_instr; n_ifpc = e_ifpc; n_exc = e_exc; n_valid = e_valid;
        if (fl) begin
            n_pc = ft; n_instr = 0; n_ifpc = 0; n_exc = 0; n_valid = 0;
        end else if (!st) begin
            n_pc = e_pc + 4;
            if (e_valid) begin
                if (sel == 2'd1 && tk) begin
                    disp = int'($signed(e_instr[15:0])) * 4;
                    n_pc = e_ifpc + 4 + 32'(disp);
                end else if (sel == 2'd2) begin
                    n_pc = ((e_ifpc + 4) & 32'hF000_0000) + (e_instr & 32'h03FF_FFFF) * 4;
                end else if (sel == 2'd3) begin
                    n_pc = jt;
                end
            end
            if (is_fault(e_pc)) begin
                n_instr = 0; n_exc = 5'd4;
            end else begin
                n_instr = mem[(e_pc - IM_BASE) / 4]; n_exc = 0;
            end
            n_ifpc = e_pc; n_valid = 1;
        end
        @(posedge clk);
        #1;
        e_pc = n_pc; e_instr = n_instr; e_ifpc = n_ifpc; e_exc = n_exc; e_valid = n_valid;
        check_all(tag);
    endtask

    task automatic run(input string tag);
        step(tag, 1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    endtask

    task automatic jr(input string tag, input logic [31:0] tgt);
        step(tag, 1'b0, 1'b0, 32'h0, 2'd3, 1'b0, tgt);
    endtask

    initial begin
        logic        r_st, r_fl, r_tk;
        logic [31:0] r_ft, r_jt;
        logic [1:0]  r_sel;

        for (int i = 0; i < IM_DEPTH; i++) mem[i] = $urandom();
        mem[0] = 32'h0800_0C10;  // j with target field 26'h0000C10
        mem[1] = 32'h1000_FFFE;  // branch with imm -2

        #12;
        check_all("reset");
        check("reset.pc8_const", if_id_pc8, 32'd8);
        #10 reset = 1'b1;

        run("seq0");
        check("seq0.first_valid", {31'd0, if_id_valid}, 32'd1);
        run("seq1");
        check("seq1.im_pc", im_pc, 32'h3008);

        // taken branch at if_id_pc 3004: delay slot 3008 enters, then 3000
        step("br_taken", 1'b0, 1'b0, 32'h0, 2'd1, 1'b1, 32'h0);
        check("br_taken.target", im_pc, 32'h3000);
        check("br_taken.slot", if_id_pc, 32'h3008);
        run("br_a");
        run("br_b");
        step("br_not", 1'b0, 1'b0, 32'h0, 2'd1, 1'b0, 32'h0);
        check("br_not.target", im_pc, 32'h300C);

        jr("jr_3000", 32'h3000);
        run("j_prep");
        step("jump", 1'b0, 1'b0, 32'h0, 2'd2, 1'b0, 32'h0);
        check("jump.target", im_pc, 32'h3040);
        jr("jr_3100", 32'h3100);
        check("jr_3100.target", im_pc, 32'h3100);

        for (int i = 0; i < 3; i++)
            step("stall", 1'b1, 1'b0, 32'h0, 2'($urandom_range(0, 3)), 1'b1, 32'h5000);
        check("stall.im_pc", im_pc, 32'h3100);
        check("stall.ifpc", if_id_pc, 32'h3040);
        run("resume");
        check("resume.im_pc", im_pc, 32'h3104);

        step("flush_stall", 1'b1, 1'b1, 32'h4180, 2'd3, 1'b1, 32'h3000);
        check("flush_stall.im_pc", im_pc, 32'h4180);
        check("flush_stall.valid", {31'd0, if_id_valid}, 32'd0);
        check("flush_stall.instr", if_id_instr, 32'h0);
        jr("bubble_jr", 32'h3002);
        check("bubble_jr.ignored", im_pc, 32'h4184);

        jr("f_mis_jr", 32'h3002);
        run("f_mis");
        check("f_mis.exc", {27'd0, if_id_exc}, 32'd4);
        check("f_mis.adv", im_pc, 32'h3006);
        jr("f_top_jr", 32'h3000 + 4 * IM_DEPTH);
        run("f_top");
        check("f_top.exc", {27'd0, if_id_exc}, 32'd4);
        jr("f_low_jr", 32'h2FFC);
        run("f_low");
        check("f_low.exc", {27'd0, if_id_exc}, 32'd4);
        check("f_low.adv", im_pc, 32'h3000);
        jr("f_last_jr", 32'h3000 + 4 * IM_DEPTH - 4);
        run("f_last");
        check("f_last.exc", {27'd0, if_id_exc}, 32'd0);
        jr("wrap_jr", 32'hFFFF_FFFC);
        run("wrap0");
        check("wrap0.im_pc", im_pc, 32'h0);
        run("wrap1");

        for (int i = 0; i < 400; i++) begin
            r_st  = ($urandom_range(0, 5) == 0);
            r_fl  = ($urandom_range(0, 11) == 0);
            r_ft  = IM_BASE + 4 * $urandom_range(0, IM_DEPTH - 1);
            if ($urandom_range(0, 7) == 0) r_ft = r_ft + $urandom_range(0, 3);
            r_sel = 2'($urandom_range(0, 3));
            r_tk  = 1'($urandom_range(0, 1));
            r_jt  = IM_BASE + 4 * $urandom_range(0, IM_DEPTH + 64) - 32'd64;
            step("rand", r_st, r_fl, r_ft, r_sel, r_tk, r_jt);
        end

        // asynchronous reset must win over stall and flush without a clock edge
        stall = 1'b1; flush = 1'b1; flush_target = 32'h7777_0000;
        #3 reset = 1'b0;
        #1;
        e_pc = 32'h3000; e_instr = 0; e_ifpc = 0; e_exc = 0; e_valid = 0;
        check_all("async_reset");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
